rlbp_pixel_comparator: RTL

//  Upstream feeder for the RLBP capture stage. Accepts one 3x3 pixel window, nine PIX_W-bit samples in

---
 rtl/rlbp_pkg.sv | 17 +
 rtl/rlbp_window_buf.sv | 33 +++
 rtl/rlbp_pixel_comparator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rlbp_pkg.sv
// Shared constants and state encoding for the RLBP pixel comparator.
package rlbp_pkg;

    localparam int unsigned NUM_TAPS   = 9;
    localparam int unsigned CENTER_IDX = 4;
    localparam int unsigned IDX_W      = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_THRESH = 3'd2,
        S_PULSE  = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/rlbp_window_buf.sv
// 3x3 window register file: one write port, one combinational read port and a
// dedicated centre tap so the threshold can be formed alongside a tap read.
module rlbp_window_buf
    import rlbp_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PIX_W-1:0] rd_data,
    output logic [PIX_W-1:0] center_data
);

    logic [PIX_W-1:0] mem [NUM_TAPS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_idx < IDX_W'(NUM_TAPS))) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data     = (rd_idx < IDX_W'(NUM_TAPS)) ? mem[rd_idx] : '0;
    assign center_data = mem[CENTER_IDX];

endmodule

// File: rtl/rlbp_pixel_comparator.sv
// Buffers one 3x3 window, thresholds every tap against centre+offset and
// streams the nine comparison bits to the downstream capture FSM.
module rlbp_pixel_comparator
    import rlbp_pkg::*;
#(
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] thr_offset,
    output logic             bit_out,
    output logic             pxl_done_o,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);
    localparam logic [IDX_W-1:0] CTR_IDX  = IDX_W'(CENTER_IDX);
    localparam logic [IDX_W-1:0] GAP_LAST = IDX_W'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] tap_cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] gap_cnt;
    logic [IDX_W-1:0] cmp_idx;
    logic [PIX_W:0]   thr_q;
    logic [PIX_W:0]   thr_calc;
    logic [PIX_W:0]   thr_cmp;
    logic [PIX_W-1:0] rd_data;
    logic [PIX_W-1:0] center_data;
    logic             wr_en;
    logic             bit_calc;
    logic             pix_ready_d;
    logic             busy_d;
    logic             pxl_done_d;
    logic             frame_done_d;

    rlbp_window_buf #(
        .PIX_W (PIX_W)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_idx      (tap_cnt),
        .wr_data     (pix_data),
        .rd_idx      (cmp_idx),
        .rd_data     (rd_data),
        .center_data (center_data)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_LOAD;
            S_LOAD:   if (pix_valid && (tap_cnt == LAST_IDX)) state_next = S_THRESH;
            S_THRESH: state_next = S_PULSE;
            S_PULSE:  state_next = S_GAP;
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = (bit_idx == LAST_IDX) ? S_DONE : S_PULSE;
                end
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output decode: values the output registers take at the next edge
    always_comb begin
        pix_ready_d  = 1'b0;
        busy_d       = 1'b0;
        pxl_done_d   = 1'b0;
        frame_done_d = 1'b0;
        pix_ready_d  = (state_next == S_LOAD);
        busy_d       = (state_next != S_IDLE);
        pxl_done_d   = (state_next == S_PULSE);
        frame_done_d = (state_next == S_DONE);
    end

    // Comparator looks one tap ahead while in GAP; in THRESH the fresh sum bypasses thr_q
    assign wr_en    = (state == S_LOAD) && pix_valid;
    assign cmp_idx  = (state == S_GAP) ? (bit_idx + IDX_W'(1)) : bit_idx;
    assign thr_calc = {1'b0, center_data} + {1'b0, thr_offset};
    assign thr_cmp  = (state == S_THRESH) ? thr_calc : thr_q;
    assign bit_calc = (cmp_idx != CTR_IDX) && ({1'b0, rd_data} >= thr_cmp);

    // Counters, threshold and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap_cnt    <= '0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            thr_q      <= '0;
            pix_ready  <= 1'b0;
            bit_out    <= 1'b0;
            pxl_done_o <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pix_ready  <= pix_ready_d;
            busy       <= busy_d;
            pxl_done_o <= pxl_done_d;
            frame_done <= frame_done_d;
            if (pxl_done_d) begin
                bit_out <= bit_calc;
            end
            case (state)
                S_IDLE: begin
                    tap_cnt <= '0;
                    bit_idx <= '0;
                    gap_cnt <= '0;
                end
                S_LOAD: begin
                    if (pix_valid && (tap_cnt != LAST_IDX)) begin
                        tap_cnt <= tap_cnt + IDX_W'(1);
                    end
                end
                S_THRESH: thr_q <= thr_calc;
                S_PULSE:  gap_cnt <= '0;
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (bit_idx != LAST_IDX) begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        gap_cnt <= gap_cnt + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
